// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 signed multiply/divide unit for the execute stage.
// Works on magnitudes during RUN, then applies the sign correction in a two-phase FIX
// step. The first phase registers the negated value and the second writes the result.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PREP = 3'd1;
   localparam logic [2:0] S_RUN  = 3'd2;
   localparam logic [2:0] S_FIX  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [1:0] OP_MUL  = 2'b00;
   localparam logic [1:0] OP_MULH = 2'b01;
   localparam logic [1:0] OP_DIV  = 2'b10;
   localparam logic [1:0] OP_REM  = 2'b11;

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   // Magnitude of a two's complement value; -2^(W-1) maps to 2^(W-1) as unsigned.
   function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? -v : v;
   endfunction

   logic [2:0]       state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] ub_q, ub_d;        // |b|: multiplicand or divisor
   logic [WIDTH:0]   hi_q, hi_d;        // product high half / partial remainder
   logic [WIDTH-1:0] lo_q, lo_d;        // multiplier-product low half / quotient
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             neg_q, neg_d;      // product or quotient negative
   logic             rneg_q, rneg_d;    // remainder negative (sign of dividend)
   logic             div0_q, div0_d;
   logic             fix_ph_q, fix_ph_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             busy_q, busy_d, done_q, done_d;

   logic             is_mul_s;
   logic [WIDTH:0]   mul_sum_s, mul_acc_s;
   logic [2*WIDTH:0] mul_sh_s;
   logic [2*WIDTH-1:0] mul_neg_s;
   logic [WIDTH:0]   div_sh_s, div_diff_s;

   assign is_mul_s   = ~op_q[1];
   assign mul_sum_s  = hi_q + {1'b0, ub_q};
   assign mul_acc_s  = lo_q[0] ? mul_sum_s : hi_q;
   assign mul_sh_s   = {mul_acc_s, lo_q} >> 1;
   assign mul_neg_s  = -{hi_q[WIDTH-1:0], lo_q};
   assign div_sh_s   = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
   assign div_diff_s = div_sh_s - {1'b0, ub_q};

   // Next-state, datapath step and result selection.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      ub_d     = ub_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      div0_d   = div0_q;
      fix_ph_d = fix_ph_q;
      result_d = result_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start && !flush) begin
               state_d = S_PREP;
               op_d    = op;
               a_d     = a;
               b_d     = b;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_PREP: begin
            ub_d     = abs_w(b_q);
            lo_d     = abs_w(a_q);
            hi_d     = '0;
            cnt_d    = '0;
            neg_d    = a_q[WIDTH-1] ^ b_q[WIDTH-1];
            rneg_d   = a_q[WIDTH-1];
            div0_d   = (b_q == {WIDTH{1'b0}});
            fix_ph_d = 1'b0;
            state_d  = S_RUN;
         end
         S_RUN: begin
            if (is_mul_s) begin
               hi_d = mul_sh_s[2*WIDTH:WIDTH];
               lo_d = mul_sh_s[WIDTH-1:0];
            end else if (!div_diff_s[WIDTH]) begin
               hi_d = div_diff_s;
               lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
               hi_d = div_sh_s;
               lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               state_d = S_FIX;
            end else begin
               state_d = S_RUN;
            end
         end
         S_FIX: begin
            if (!fix_ph_q) begin
               fix_ph_d = 1'b1;
               if (is_mul_s) begin
                  if (neg_q) begin
                     hi_d = {1'b0, mul_neg_s[2*WIDTH-1:WIDTH]};
                     lo_d = mul_neg_s[WIDTH-1:0];
                  end else begin
                     hi_d = hi_q;
                  end
               end else begin
                  if (neg_q) begin
                     lo_d = -lo_q;
                  end else begin
                     lo_d = lo_q;
                  end
                  if (rneg_q) begin
                     hi_d = {1'b0, -hi_q[WIDTH-1:0]};
                  end else begin
                     hi_d = hi_q;
                  end
               end
            end else begin
               state_d = S_DONE;
               case (op_q)
                  OP_MUL:  result_d = lo_q;
                  OP_MULH: result_d = hi_q[WIDTH-1:0];
                  OP_DIV:  result_d = div0_q ? {WIDTH{1'b1}} : lo_q;
                  OP_REM:  result_d = div0_q ? a_q : hi_q[WIDTH-1:0];
                  default: result_d = lo_q;
               endcase
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (flush) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end else begin
         state_d = state_d;
      end
      busy_d = (state_d == S_PREP) || (state_d == S_RUN) || (state_d == S_FIX);
      done_d = (state_d == S_DONE);
   end

   // State and datapath registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         op_q     <= 2'b00;
         a_q      <= '0;
         b_q      <= '0;
         ub_q     <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         div0_q   <= 1'b0;
         fix_ph_q <= 1'b0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         ub_q     <= ub_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         div0_q   <= div0_d;
         fix_ph_q <= fix_ph_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with hand-computed results for muldiv_unit.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op_i = 2'b00;
   logic [31:0] a_i = 32'd0;
   logic [31:0] b_i = 32'd0;
   logic        flush = 1'b0;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int tests = 0;
   int fails = 0;
   int lat;
   int dcount;
   logic [31:0] last_res;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op_i), .a(a_i), .b(b_i),
      .flush(flush), .busy(busy), .done(done), .result(result)
   );

   // 10 ns clock.
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive a one-cycle start; returns 1 ns after the accepting edge.
   task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      op_i = o; a_i = x; b_i = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a_i = 32'd0; b_i = 32'd0;
   endtask

   // Wait (bounded) for done; optionally pulse ignored starts while busy.
   task automatic wait_done(input bit noise);
      lat = 0;
      while (!done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (noise && (lat == 5 || lat == 20)) begin
            start = 1'b1; op_i = 2'b10; a_i = 32'd100; b_i = 32'd7;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
   endtask

   task automatic run(input string tag, input logic [1:0] o, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] exp);
      start_op(o, x, y);
      wait_done(1'b0);
      chk({tag, "_lat"}, lat, 32'd35);
      chk({tag, "_res"}, result, exp);
      last_res = exp;
   endtask

   initial begin
      #12;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_result", result, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      run("mul_7_m3", 2'b00, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
      @(posedge clk); #1;
      chk("done_one_cycle", {31'd0, done}, 32'd0);
      run("mulh_min_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      run("mulh_m1_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
      run("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      run("rem_m7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      run("rem_7_m2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'd1);
      run("div_5_0", 2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF);
      run("rem_5_0", 2'b11, 32'd5, 32'd0, 32'd5);
      run("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      run("rem_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      run("div_100_m7", 2'b10, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2);
      run("mul_big", 2'b00, 32'h0001_0003, 32'h0001_0005, 32'h0008_000F);

      // Start pulses while busy are ignored.
      start_op(2'b00, 32'd2, 32'd3);
      wait_done(1'b1);
      chk("noise_lat", lat, 32'd35);
      chk("noise_res", result, 32'd6);

      // Back-to-back start while in DONE.
      start_op(2'b11, 32'd100, 32'd7);
      chk("b2b_done_low", {31'd0, done}, 32'd0);
      chk("b2b_busy", {31'd0, busy}, 32'd1);
      chk("b2b_res_held", result, 32'd6);
      wait_done(1'b0);
      chk("b2b_lat", lat, 32'd35);
      chk("b2b_res", result, 32'd2);
      last_res = 32'd2;

      // Flush at RUN count 10.
      @(posedge clk); #1;
      start_op(2'b00, 32'd3, 32'd3);
      repeat (11) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_busy", {31'd0, busy}, 32'd0);
      chk("flush_done", {31'd0, done}, 32'd0);
      chk("flush_res", result, last_res);
      dcount = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done) dcount++;
      end
      chk("flush_no_done", dcount, 32'd0);
      chk("flush_res_kept", result, last_res);

      // Flush wins over a simultaneous start.
      op_i = 2'b00; a_i = 32'd4; b_i = 32'd4; start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      chk("flush_vs_start", {31'd0, busy}, 32'd0);

      // Asynchronous reset in the middle of RUN.
      start_op(2'b10, 32'd100, 32'd7);
      repeat (6) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_done", {31'd0, done}, 32'd0);
      chk("arst_result", result, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      run("post_rst_rem", 2'b11, 32'd100, 32'd7, 32'd2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
